icache_direct_mapped: RTL and testbench

- Direct-mapped instruction cache sitting directly upstream of the pipelined datapath's IF stage.
- Serves IF fetches: `i_address` in, `i_data` plus a ready flag out, over a line-based request/acknowledge port to instruction memory.
- On a miss it raises `i_stall` so the hazard control unit freezes PC and IF/ID.
- Keeps hit and miss counters for performance reporting next to `num_branch_miss`.

---
 rtl/icache_direct_mapped_pkg.sv | 19 +
 rtl/icache_line_array.sv | 63 ++++++
 rtl/icache_direct_mapped.sv | 136 +++++++++++++
 tb/tb_icache_direct_mapped.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// rtl/icache_direct_mapped_pkg.sv - shared constants and state encoding for the direct-mapped icache
package icache_direct_mapped_pkg;

   localparam int ICACHE_LINE_WORDS = 4;
   localparam int ICACHE_NUM_LINES  = 4;

   // Address layout: [tag | index | offset], offset in the low bits.
   localparam int IC_OFF_W   = 2;
   localparam int IC_IDX_W   = 2;
   localparam int IC_IDX_LSB = IC_OFF_W;
   localparam int IC_TAG_LSB = IC_OFF_W + IC_IDX_W;

   typedef enum logic [1:0] {
      IC_IDLE     = 2'd0,
      IC_MISS_REQ = 2'd1,
      IC_FILL     = 2'd2
   } ic_state_e;

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - tag/valid/data storage with combinational read and synchronous line write
module icache_line_array
   import icache_direct_mapped_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS,
   parameter int NUM_LINES  = ICACHE_NUM_LINES,
   parameter int IDX_W      = IC_IDX_W,
   parameter int TAG_W      = WORD_SIZE - IC_TAG_LSB
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [IDX_W-1:0]                 rd_index,
   output logic                             rd_valid,
   output logic [TAG_W-1:0]                 rd_tag,
   output logic [LINE_WORDS*WORD_SIZE-1:0]  rd_line,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_index,
   input  logic [TAG_W-1:0]                 wr_tag,
   input  logic [LINE_WORDS*WORD_SIZE-1:0]  wr_line,
   input  logic                             wr_valid,
   input  logic                             clear_all
);

   logic [NUM_LINES-1:0]             valid_q, valid_d;
   logic [TAG_W-1:0]                 tag_q  [NUM_LINES];
   logic [TAG_W-1:0]                 tag_d  [NUM_LINES];
   logic [LINE_WORDS*WORD_SIZE-1:0]  line_q [NUM_LINES];
   logic [LINE_WORDS*WORD_SIZE-1:0]  line_d [NUM_LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_line  = line_q[rd_index];

   // clear_all wins over a same-cycle fill so an invalidated fill never becomes visible.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      line_d  = line_q;
      if (wr_en) begin
         valid_d[wr_index] = wr_valid;
         tag_d[wr_index]   = wr_tag;
         line_d[wr_index]  = wr_line;
      end
      if (clear_all) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      line_q <= line_d;
   end

endmodule

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped instruction cache feeding the IF stage, with miss FSM and perf counters
module icache_direct_mapped
   import icache_direct_mapped_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int LINE_WORDS = ICACHE_LINE_WORDS,
   parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             i_readM,
   input  logic [WORD_SIZE-1:0]             i_address,
   output logic [WORD_SIZE-1:0]             i_data,
   output logic                             i_ready,
   output logic                             i_stall,
   input  logic                             invalidate,
   output logic                             mem_req,
   output logic [WORD_SIZE-1:0]             mem_addr,
   input  logic                             mem_ack,
   input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_line,
   output logic [WORD_SIZE-1:0]             num_hit,
   output logic [WORD_SIZE-1:0]             num_miss
);

   localparam int TAG_W = WORD_SIZE - IC_TAG_LSB;

   logic [IC_OFF_W-1:0]             off;
   logic [IC_IDX_W-1:0]             idx;
   logic [TAG_W-1:0]                tag;
   logic                            rd_valid;
   logic [TAG_W-1:0]                rd_tag;
   logic [LINE_WORDS*WORD_SIZE-1:0] rd_line;
   logic                            hit;

   ic_state_e                       state_q, state_d;
   logic                            mem_req_q, mem_req_d;
   logic [WORD_SIZE-1:0]            mem_addr_q, mem_addr_d;
   logic [LINE_WORDS*WORD_SIZE-1:0] fill_q, fill_d;
   logic                            drop_q, drop_d;
   logic [WORD_SIZE-1:0]            num_hit_q, num_hit_d;
   logic [WORD_SIZE-1:0]            num_miss_q, num_miss_d;

   assign off = i_address[IC_OFF_W-1:0];
   assign idx = i_address[IC_TAG_LSB-1:IC_IDX_LSB];
   assign tag = i_address[WORD_SIZE-1:IC_TAG_LSB];

   // The latched line address doubles as the fill index/tag, so no separate miss latch is kept.
   icache_line_array #(
      .WORD_SIZE  (WORD_SIZE),
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .IDX_W      (IC_IDX_W),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_index   (idx),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .rd_line    (rd_line),
      .wr_en      (state_q == IC_FILL),
      .wr_index   (mem_addr_q[IC_TAG_LSB-1:IC_IDX_LSB]),
      .wr_tag     (mem_addr_q[WORD_SIZE-1:IC_TAG_LSB]),
      .wr_line    (fill_q),
      .wr_valid   (~drop_q),
      .clear_all  (invalidate)
   );

   assign hit      = rd_valid && (rd_tag == tag);
   assign i_ready  = i_readM && hit && (state_q == IC_IDLE);
   assign i_data   = hit ? rd_line[32'(off)*WORD_SIZE +: WORD_SIZE] : '0;
   assign i_stall  = i_readM && !i_ready;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign num_hit  = num_hit_q;
   assign num_miss = num_miss_q;

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fill_d     = fill_q;
      drop_d     = drop_q;
      num_hit_d  = num_hit_q + WORD_SIZE'(i_ready);
      num_miss_d = num_miss_q;
      case (state_q)
         IC_IDLE: begin
            if (i_readM && !hit) begin
               mem_req_d  = 1'b1;
               mem_addr_d = {i_address[WORD_SIZE-1:IC_OFF_W], {IC_OFF_W{1'b0}}};
               num_miss_d = num_miss_q + WORD_SIZE'(1);
               state_d    = IC_MISS_REQ;
            end
         end
         IC_MISS_REQ: begin
            if (invalidate) begin
               drop_d = 1'b1;
            end
            if (mem_ack) begin
               fill_d    = mem_line;
               mem_req_d = 1'b0;
               state_d   = IC_FILL;
            end
         end
         IC_FILL: begin
            drop_d  = 1'b0;
            state_d = IC_IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IC_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fill_q     <= '0;
         drop_q     <= 1'b0;
         num_hit_q  <= '0;
         num_miss_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fill_q     <= fill_d;
         drop_q     <= drop_d;
         num_hit_q  <= num_hit_d;
         num_miss_q <= num_miss_d;
      end
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;

   logic        clk;
   logic        reset_n;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data;
   logic        i_ready;
   logic        i_stall;
   logic        invalidate;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_line;
   logic [15:0] num_hit;
   logic [15:0] num_miss;

   int n_pass;
   int n_total;

   icache_direct_mapped dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_readM    (i_readM),
      .i_address  (i_address),
      .i_data     (i_data),
      .i_ready    (i_ready),
      .i_stall    (i_stall),
      .invalidate (invalidate),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_line   (mem_line),
      .num_hit    (num_hit),
      .num_miss   (num_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic        inv;
      logic        ack;
      logic [63:0] line;
      logic        e_ready;
      logic [15:0] e_data;
      logic        e_req;
      logic [15:0] e_addr;
      logic [15:0] e_hits;
      logic [15:0] e_miss;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic [15:0] addr, input logic inv, input logic ack,
                               input logic [63:0] line, input logic e_ready, input logic [15:0] e_data,
                               input logic e_req, input logic [15:0] e_addr, input logic [15:0] e_hits,
                               input logic [15:0] e_miss);
      vec_t v;
      v.rd = rd; v.addr = addr; v.inv = inv; v.ack = ack; v.line = line;
      v.e_ready = e_ready; v.e_data = e_data; v.e_req = e_req; v.e_addr = e_addr;
      v.e_hits = e_hits; v.e_miss = e_miss;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic rd, input logic [15:0] a, input logic inv, input logic ack, input logic [63:0] ln);
      i_readM = rd; i_address = a; invalidate = inv; mem_ack = ack; mem_line = ln;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   localparam logic [63:0] L1 = 64'h4444_3333_2222_1111;
   localparam logic [63:0] L2 = 64'hBBBB_AAAA_9999_8888;

   // Reference model state: what the cache holds and whether a miss is outstanding.
   logic        m_valid [4];
   logic [11:0] m_tag   [4];
   logic [63:0] m_data  [4];
   logic        m_pend, m_acked, m_drop, m_hit;
   logic [15:0] m_paddr;
   logic [63:0] m_buf;
   int          m_hits, m_miss;

   initial begin
      n_pass = 0;
      n_total = 0;
      do_reset();

      drive(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);
      #1;
      chk("reset mem_req", mem_req, 1'b0);
      chk("reset mem_addr", mem_addr, 16'h0);
      chk("reset num_hit", num_hit, 16'h0);
      chk("reset num_miss", num_miss, 16'h0);
      chk("reset i_ready", i_ready, 1'b0);

      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    1, 16'h0,  0, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    1, 16'h0,  0, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 1, L1,    0, 16'h0,    1, 16'h0,  0, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  0, 1));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 1, 16'h1111, 0, 16'h0,  0, 1));
      vecs.push_back(mk(1, 16'h0001, 0, 0, 64'h0, 1, 16'h2222, 0, 16'h0,  1, 1));
      vecs.push_back(mk(1, 16'h0002, 0, 0, 64'h0, 1, 16'h3333, 0, 16'h0,  2, 1));
      vecs.push_back(mk(1, 16'h0003, 0, 0, 64'h0, 1, 16'h4444, 0, 16'h0,  3, 1));
      vecs.push_back(mk(1, 16'h0010, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  4, 1));
      vecs.push_back(mk(1, 16'h0010, 0, 1, L2,    0, 16'h0,    1, 16'h10, 4, 2));
      vecs.push_back(mk(1, 16'h0010, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  4, 2));
      vecs.push_back(mk(1, 16'h0010, 0, 0, 64'h0, 1, 16'h8888, 0, 16'h0,  4, 2));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  5, 2));
      vecs.push_back(mk(1, 16'h0000, 0, 1, L1,    0, 16'h0,    1, 16'h0,  5, 3));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  5, 3));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 1, 16'h1111, 0, 16'h0,  5, 3));
      vecs.push_back(mk(1, 16'h0000, 1, 0, 64'h0, 1, 16'h1111, 0, 16'h0,  6, 3));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  7, 3));
      vecs.push_back(mk(1, 16'h0000, 1, 0, 64'h0, 0, 16'h0,    1, 16'h0,  7, 4));
      vecs.push_back(mk(1, 16'h0000, 0, 1, L1,    0, 16'h0,    1, 16'h0,  7, 4));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  7, 4));
      vecs.push_back(mk(1, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    0, 16'h0,  7, 4));
      vecs.push_back(mk(0, 16'h0000, 0, 0, 64'h0, 0, 16'h0,    1, 16'h0,  7, 5));

      foreach (vecs[i]) begin
         drive(vecs[i].rd, vecs[i].addr, vecs[i].inv, vecs[i].ack, vecs[i].line);
         #1;
         chk($sformatf("vec%0d i_ready", i), i_ready, vecs[i].e_ready);
         chk($sformatf("vec%0d i_stall", i), i_stall, vecs[i].rd & ~vecs[i].e_ready);
         if (vecs[i].e_ready) chk($sformatf("vec%0d i_data", i), i_data, vecs[i].e_data);
         chk($sformatf("vec%0d mem_req", i), mem_req, vecs[i].e_req);
         if (vecs[i].e_req) chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d num_hit", i), num_hit, vecs[i].e_hits);
         chk($sformatf("vec%0d num_miss", i), num_miss, vecs[i].e_miss);
         tick();
      end

      // Reset while a request is outstanding, then a stale ack.
      drive(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("midmiss pre mem_req", mem_req, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("midmiss rst mem_req", mem_req, 1'b0);
      chk("midmiss rst mem_addr", mem_addr, 16'h0);
      chk("midmiss rst num_hit", num_hit, 16'h0);
      chk("midmiss rst num_miss", num_miss, 16'h0);
      tick();
      reset_n = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b1, L2);
      #1;
      chk("stale ack mem_req", mem_req, 1'b0);
      tick();
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);
      #1;
      chk("post stale mem_req", mem_req, 1'b0);
      chk("post stale i_ready", i_ready, 1'b0);
      chk("post stale i_stall", i_stall, 1'b1);
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("post stale new req", mem_req, 1'b1);
      chk("post stale num_miss", num_miss, 16'h1);

      // Randomized phase against the reference model.
      do_reset();
      for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
      m_pend = 0; m_acked = 0; m_drop = 0; m_paddr = 0; m_buf = 0;
      m_hits = 0; m_miss = 0;
      for (int c = 0; c < 3000; c++) begin
         logic        rd, inv, ack;
         logic [15:0] a;
         logic [63:0] ln;
         int          ix, of;
         rd  = ($urandom_range(0, 3) != 0);
         a   = 16'($urandom_range(0, 47));
         inv = ($urandom_range(0, 24) == 0);
         ack = ($urandom_range(0, 2) == 0);
         ln  = {$urandom, $urandom};
         drive(rd, a, inv, ack, ln);
         #1;
         ix = int'(a[3:2]);
         of = int'(a[1:0]);
         m_hit = !m_pend && rd && m_valid[ix] && (m_tag[ix] == a[15:4]);
         chk($sformatf("rnd%0d i_ready", c), i_ready, m_hit);
         chk($sformatf("rnd%0d i_stall", c), i_stall, rd & ~m_hit);
         if (m_hit) chk($sformatf("rnd%0d i_data", c), i_data, m_data[ix][of*16 +: 16]);
         chk($sformatf("rnd%0d mem_req", c), mem_req, m_pend & ~m_acked);
         if (m_pend && !m_acked) chk($sformatf("rnd%0d mem_addr", c), mem_addr, m_paddr);
         chk($sformatf("rnd%0d num_hit", c), num_hit, 16'(m_hits));
         chk($sformatf("rnd%0d num_miss", c), num_miss, 16'(m_miss));
         if (m_pend && m_acked) begin
            if (!m_drop) begin
               m_valid[int'(m_paddr[3:2])] = 1'b1;
               m_tag[int'(m_paddr[3:2])]   = m_paddr[15:4];
               m_data[int'(m_paddr[3:2])]  = m_buf;
            end
            m_pend = 0;
            m_drop = 0;
         end else if (m_pend) begin
            if (inv) m_drop = 1;
            if (ack) begin
               m_acked = 1;
               m_buf   = ln;
            end
         end else if (rd && !m_hit) begin
            m_pend  = 1;
            m_acked = 0;
            m_paddr = a & 16'hFFFC;
            m_miss++;
         end
         if (m_hit) m_hits++;
         if (inv) for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
